// File: rtl/tpu_tile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : tpu_tile_sequencer_pkg
// Brief   : State encodings and shared constants for the TPU tile sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package tpu_tile_sequencer_pkg;

    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_MATRIX_SIZE = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_W = 3'd1,
        S_LOAD_W = 3'd2,
        S_FEED   = 3'd3,
        S_DRAIN  = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_seq_counter.sv
`default_nettype none
// ============================================================================
// Module : tpu_seq_counter
// Brief  : Loadable down-counter with zero flag; saturates at zero.
// Rev    : 1.0  initial release
// ============================================================================
module tpu_seq_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tpu_tile_sequencer
// Brief  : Runs one matrix-multiply tile: weight pop/reload, activation feed,
//          pipeline drain and result write-back, with start/done handshake.
// Rev    : 1.0  initial release
// ============================================================================
module tpu_tile_sequencer
    import tpu_tile_sequencer_pkg::*;
#(
    parameter int ADDRESSSIZE  = DEF_ADDRESSSIZE,
    parameter int MATRIX_SIZE  = DEF_MATRIX_SIZE,
    parameter int WLOAD_CYCLES = 32,
    parameter int PIPE_LAT     = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    input  logic                   fifo_empty,
    output logic                   busy,
    output logic                   done,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_read_en,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address
);

    localparam int c_CNT_W = $clog2(max3(WLOAD_CYCLES, PIPE_LAT, MATRIX_SIZE) + 1);
    localparam logic [c_CNT_W-1:0] c_WLOAD_INIT = c_CNT_W'(WLOAD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ROWS_INIT  = c_CNT_W'(MATRIX_SIZE - 1);
    localparam logic [c_CNT_W-1:0] c_PIPE_INIT  = c_CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    seq_state_e             r_state;
    seq_state_e             w_state_next;
    logic [ADDRESSSIZE-1:0] r_ub_base;
    logic [ADDRESSSIZE-1:0] r_res_base;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pop;
    logic                   r_we_rl;
    logic                   r_ub_en;
    logic                   r_res_we;
    logic [ADDRESSSIZE-1:0] r_ub_address;
    logic [ADDRESSSIZE-1:0] r_res_address;

    logic                   w_busy;
    logic                   w_done;
    logic                   w_pop;
    logic                   w_we_rl;
    logic                   w_ub_en;
    logic                   w_res_we;
    logic [ADDRESSSIZE-1:0] w_ub_addr;
    logic [ADDRESSSIZE-1:0] w_res_addr;
    logic                   w_latch;
    logic                   w_cnt_load;
    logic [c_CNT_W-1:0]     w_cnt_value;
    logic                   w_cnt_en;
    logic                   w_cnt_zero;

    tpu_seq_counter #(
        .WIDTH (c_CNT_W)
    ) u_step_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .i_en    (w_cnt_en),
        .o_zero  (w_cnt_zero)
    );

    // Outputs are decided for the state being entered, so each strobe lines up
    // with its state register value; each counted state leaves on counter zero.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_pop        = 1'b0;
        w_we_rl      = 1'b0;
        w_ub_en      = 1'b0;
        w_res_we     = 1'b0;
        w_ub_addr    = r_ub_address;
        w_res_addr   = r_res_address;
        w_latch      = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_value  = '0;
        w_cnt_en     = 1'b0;
        if (abort) begin
            w_state_next = S_IDLE;
            w_cnt_load   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next = S_WAIT_W;
                        w_latch      = 1'b1;
                    end
                end
                S_WAIT_W: begin
                    if (!fifo_empty) begin
                        w_state_next = S_LOAD_W;
                        w_pop        = 1'b1;
                        w_we_rl      = 1'b1;
                        w_cnt_load   = 1'b1;
                        w_cnt_value  = c_WLOAD_INIT;
                    end
                end
                S_LOAD_W: begin
                    if (w_cnt_zero) begin
                        w_state_next = S_FEED;
                        w_ub_en      = 1'b1;
                        w_ub_addr    = r_ub_base;
                        w_cnt_load   = 1'b1;
                        w_cnt_value  = c_ROWS_INIT;
                    end else begin
                        w_we_rl  = 1'b1;
                        w_cnt_en = 1'b1;
                    end
                end
                S_FEED: begin
                    if (w_cnt_zero) begin
                        if (PIPE_LAT == 0) begin
                            w_state_next = S_WRITE;
                            w_res_we     = 1'b1;
                            w_res_addr   = r_res_base;
                            w_cnt_load   = 1'b1;
                            w_cnt_value  = c_ROWS_INIT;
                        end else begin
                            w_state_next = S_DRAIN;
                            w_cnt_load   = 1'b1;
                            w_cnt_value  = c_PIPE_INIT;
                        end
                    end else begin
                        w_ub_en   = 1'b1;
                        w_ub_addr = r_ub_address + ADDRESSSIZE'(1);
                        w_cnt_en  = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_cnt_zero) begin
                        w_state_next = S_WRITE;
                        w_res_we     = 1'b1;
                        w_res_addr   = r_res_base;
                        w_cnt_load   = 1'b1;
                        w_cnt_value  = c_ROWS_INIT;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_cnt_zero) begin
                        w_state_next = S_DONE;
                        w_done       = 1'b1;
                    end else begin
                        w_res_we   = 1'b1;
                        w_res_addr = r_res_address + ADDRESSSIZE'(1);
                        w_cnt_en   = 1'b1;
                    end
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign w_busy = (w_state_next != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_ub_base     <= '0;
            r_res_base    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pop         <= 1'b0;
            r_we_rl       <= 1'b0;
            r_ub_en       <= 1'b0;
            r_res_we      <= 1'b0;
            r_ub_address  <= '0;
            r_res_address <= '0;
        end else begin
            r_state       <= w_state_next;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_pop         <= w_pop;
            r_we_rl       <= w_we_rl;
            r_ub_en       <= w_ub_en;
            r_res_we      <= w_res_we;
            r_ub_address  <= w_ub_addr;
            r_res_address <= w_res_addr;
            if (w_latch) begin
                r_ub_base  <= ub_base;
                r_res_base <= res_base;
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign fifo_read_enable = r_pop;
    assign we_rl            = r_we_rl;
    assign ub_read_en       = r_ub_en;
    assign ub_address       = r_ub_address;
    assign res_write_enable = r_res_we;
    assign res_address      = r_res_address;

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_tpu_tile_sequencer
// Brief  : Self-checking bench for tpu_tile_sequencer (vector table, random
//          tiles against a tile-level reference model, hand-written corners).
// Rev    : 1.0  initial release
// ============================================================================
module tb_tpu_tile_sequencer;

    localparam int A = 10;
    localparam int M = 32;
    localparam int W = 32;
    localparam int P = 64;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [A-1:0] ub_base = '0;
    logic [A-1:0] res_base = '0;
    logic         fifo_empty = 1'b1;
    logic         busy, done, fifo_read_enable, we_rl, ub_read_en, res_write_enable;
    logic [A-1:0] ub_address, res_address;

    tpu_tile_sequencer #(
        .ADDRESSSIZE  (A),
        .MATRIX_SIZE  (M),
        .WLOAD_CYCLES (W),
        .PIPE_LAT     (P)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .abort            (abort),
        .ub_base          (ub_base),
        .res_base         (res_base),
        .fifo_empty       (fifo_empty),
        .busy             (busy),
        .done             (done),
        .fifo_read_enable (fifo_read_enable),
        .we_rl            (we_rl),
        .ub_read_en       (ub_read_en),
        .ub_address       (ub_address),
        .res_write_enable (res_write_enable),
        .res_address      (res_address)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor state for the current tile
    int start_edge, pop_cnt, pop_edge, we_cnt, done_cnt, prepop, last_feed, first_write;
    int ub_q[$];
    int res_q[$];

    always @(negedge clk) begin
        if (busy && !fifo_read_enable && !we_rl && !ub_read_en && !res_write_enable && !done
            && pop_cnt == 0)
            prepop++;
        if (fifo_read_enable) begin pop_cnt++; pop_edge = edge_n; end
        if (we_rl) we_cnt++;
        if (ub_read_en) begin ub_q.push_back(int'(ub_address)); last_feed = edge_n; end
        if (res_write_enable) begin
            if (res_q.size() == 0) first_write = edge_n;
            res_q.push_back(int'(res_address));
        end
        if (done) done_cnt++;
    end

    function automatic logic [31:0] outs();
        return {6'd0, busy, done, fifo_read_enable, we_rl, ub_read_en, res_write_enable,
                ub_address, res_address};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        pop_cnt = 0; pop_edge = -1; we_cnt = 0; done_cnt = 0; prepop = 0;
        last_feed = -1; first_write = -1;
        ub_q.delete();
        res_q.delete();
    endtask

    task automatic start_tile(input int ub, input int res, input int fw);
        ub_base    = A'(ub);
        res_base   = A'(res);
        fifo_empty = (fw > 0);
        start      = 1'b1;
        clear_mon();
        tick();
        start      = 1'b0;
        start_edge = edge_n;
    endtask

    task automatic wait_done(input int fw, output int lat);
        lat = -1;
        for (int n = 1; n <= 2000; n++) begin
            fifo_empty = (n <= fw);
            tick();
            if (done === 1'b1) begin
                lat = edge_n - start_edge;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    // Reference: tile timeline from the state durations, addresses as base+k mod 2^A
    task automatic check_tile(input int ub, input int res, input int fw, input int lat);
        int bad_ub, bad_res;
        chk("latency", lat, 1 + fw + W + M + P + M);
        chk("pop_count", pop_cnt, 1);
        chk("pop_edge", pop_edge - start_edge, 1 + fw);
        chk("wait_quiet_cycles", prepop, fw + 1);
        chk("we_rl_cycles", we_cnt, W);
        chk("ub_rows", ub_q.size(), M);
        chk("res_rows", res_q.size(), M);
        bad_ub = 0;
        bad_res = 0;
        foreach (ub_q[k])  if (ub_q[k]  != (ub + k)  % (1 << A)) bad_ub++;
        foreach (res_q[k]) if (res_q[k] != (res + k) % (1 << A)) bad_res++;
        chk("ub_addr_errors", bad_ub, 0);
        chk("res_addr_errors", bad_res, 0);
        chk("drain_gap", first_write - last_feed - 1, P);
        chk("done_pulses", done_cnt, 1);
    endtask

    task automatic run_tile(input int ub, input int res, input int fw, output int lat);
        start_tile(ub, res, fw);
        wait_done(fw, lat);
        tick();
        check_tile(ub, res, fw, lat);
    endtask

    typedef struct {
        int ub;
        int res;
        int fw;
        int lat;
        int ub_last;
        int res_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat, cnt, last;
        int rub, rres, rfw;
        bit found;

        vecs[0] = '{ub: 0,    res: 0,    fw: 0,  lat: 161, ub_last: 31,  res_last: 31};
        vecs[1] = '{ub: 0,    res: 0,    fw: 10, lat: 171, ub_last: 31,  res_last: 31};
        vecs[2] = '{ub: 1000, res: 1010, fw: 0,  lat: 161, ub_last: 7,   res_last: 17};
        vecs[3] = '{ub: 512,  res: 1023, fw: 2,  lat: 163, ub_last: 543, res_last: 30};

        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rstn = 1'b1;
        tick();
        tick();
        chk("idle_outputs", outs(), 0);

        for (int i = 0; i < 4; i++) begin
            run_tile(vecs[i].ub, vecs[i].res, vecs[i].fw, lat);
            chk("tbl_latency", lat, vecs[i].lat);
            last = (ub_q.size() > 0) ? ub_q[ub_q.size()-1] : -1;
            chk("tbl_ub_last", last, vecs[i].ub_last);
            last = (res_q.size() > 0) ? res_q[res_q.size()-1] : -1;
            chk("tbl_res_last", last, vecs[i].res_last);
            chk("tbl_ub_first", (ub_q.size() > 0) ? ub_q[0] : -1, vecs[i].ub);
        end

        for (int i = 0; i < 4; i++) begin
            rub  = int'($urandom_range(0, 1023));
            rres = int'($urandom_range(0, 1023));
            rfw  = int'($urandom_range(0, 5));
            run_tile(rub, rres, rfw, lat);
        end

        // Abort at FEED row k=5
        start_tile(10, 20, 0);
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (ub_read_en && ub_address == A'(15)) begin found = 1'b1; break; end
        end
        chk("abort_reach_feed", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_to_idle", {busy, done, fifo_read_enable, we_rl, ub_read_en, res_write_enable}, 0);
        repeat (100) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_feed_rows", ub_q.size(), 6);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_beats_start", busy, 0);
        run_tile(300, 400, 0, lat);

        // start pulsed mid-tile is ignored; start during DONE ignored, in IDLE honoured
        start_tile(200, 300, 0);
        for (int n = 0; n < 100; n++) begin
            tick();
            if (ub_read_en) break;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, lat);
        chk("feed_start_latency", lat, 161);
        start = 1'b1;
        tick();
        chk("start_in_done_ignored", busy, 0);
        tick();
        chk("start_after_done", busy, 1);
        start = 1'b0;
        chk("single_done", done_cnt, 1);
        clear_mon();
        start_edge = edge_n;
        wait_done(0, lat);
        tick();
        check_tile(200, 300, 0, lat);

        // Asynchronous reset during WRITE
        start_tile(5, 6, 0);
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (res_write_enable) begin found = 1'b1; break; end
        end
        chk("reset_reach_write", found, 1);
        repeat (3) tick();
        #2 rstn = 1'b0;
        #1 chk("async_reset_outputs", outs(), 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        cnt = res_q.size();
        repeat (100) tick();
        chk("no_write_after_reset", res_q.size(), cnt);
        chk("reset_idle_busy", busy, 0);
        chk("reset_no_done", done_cnt, 0);
        run_tile(77, 88, 1, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
